fib_pair_serializer: RTL and testbench



---
 rtl/fib_pair_serializer.sv | 93 +++++++++
 tb/tb_fib_pair_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_pair_serializer.sv
// Serializes {n, n+1} Fibonacci term pairs into one term per cycle with a running index,
// and latches a sticky flag when a term is smaller than the one emitted before it.
module fib_pair_serializer #(
    parameter int W     = 16,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_num,
    input  logic [W-1:0]     in_num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             wrap
);

    typedef enum logic [1:0] {
        EMPTY,
        FIRST,
        SECOND
    } state_t;

    state_t         state;
    logic [W-1:0]   hi;
    logic [W-1:0]   prev;
    logic           first;
    logic           out_fire;

    assign out_fire = out_valid & out_ready;

    // The second term's slot frees up in the same cycle it is taken downstream.
    assign in_ready = (state == EMPTY) | ((state == SECOND) & out_ready);

    // The low term of a pair is loaded straight into out_data; only the high term needs its own slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            hi        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            wrap      <= 1'b0;
            prev      <= '0;
            first     <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        hi        <= in_num2;
                        out_data  <= in_num;
                        out_valid <= 1'b1;
                        state     <= FIRST;
                    end
                end
                FIRST: begin
                    if (out_ready) begin
                        out_data <= hi;
                        state    <= SECOND;
                    end
                end
                SECOND: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            hi       <= in_num2;
                            out_data <= in_num;
                            state    <= FIRST;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase

            // A decrease between consecutive emitted terms means the upstream sum wrapped.
            if (out_fire) begin
                out_idx <= out_idx + IDX_W'(1);
                if (!first && (out_data < prev))
                    wrap <= 1'b1;
                prev  <= out_data;
                first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Scoreboard bench for fib_pair_serializer: expected terms are queued when a pair is
// accepted and compared on every output handshake, with a reference model of the wrap flag.
module tb_fib_pair_serializer;

    localparam int W     = 16;
    localparam int IDX_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_num;
    logic [W-1:0]     in_num2;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_idx;
    logic             wrap;

    fib_pair_serializer #(.W(W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_num2   (in_num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [31:0] exp_q[$];
    int          hs_cyc[$];
    int          cycle = 0;
    logic [IDX_W-1:0] exp_idx = '0;
    logic [W-1:0]     model_prev = '0;
    logic             model_first = 1'b1;
    logic             model_wrap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors_applied++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Output monitor: everything is stable at the falling edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e[31:16]));
                chk("out_idx", 32'(out_idx), 32'(e[15:0]));
                chk("wrap", 32'(wrap), 32'(model_wrap));
                $display("out term idx=%0d data=%0d wrap=%0d", out_idx, out_data, wrap);
                if (!model_first && (e[31:16] < model_prev))
                    model_wrap = 1'b1;
                model_prev  = e[31:16];
                model_first = 1'b0;
                hs_cyc.push_back(cycle);
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        exp_idx     = '0;
        model_prev  = '0;
        model_first = 1'b1;
        model_wrap  = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_num   = '0;
        in_num2  = '0;
        rst      = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_num   = a;
        in_num2  = b;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({a, exp_idx});
                exp_idx = exp_idx + 1'b1;
                exp_q.push_back({b, exp_idx});
                exp_idx = exp_idx + 1'b1;
                $display("in pair {%0d,%0d} accepted", a, b);
                acc = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        chk("drain_timeout", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] fa, fb;
        bit seen;

        out_ready = 1'b1;
        do_reset();

        // Reset then idle
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Single pair
        send_pair(16'd1, 16'd1);
        go_idle();
        wait_drain();
        chk("single_idle_valid", 32'(out_valid), 32'd0);
        chk("single_wrap", 32'(wrap), 32'd0);

        // Full rate, no bubbles
        do_reset();
        hs_cyc.delete();
        send_pair(16'd1, 16'd1);
        send_pair(16'd2, 16'd3);
        send_pair(16'd5, 16'd8);
        send_pair(16'd13, 16'd21);
        go_idle();
        wait_drain();
        chk("full_rate_count", 32'(hs_cyc.size()), 32'd8);
        if (hs_cyc.size() == 8)
            chk("full_rate_span", 32'(hs_cyc[7] - hs_cyc[0]), 32'd7);

        // Backpressure while term 5 (idx 4) is shown
        do_reset();
        fork
            begin
                send_pair(16'd1, 16'd1);
                send_pair(16'd2, 16'd3);
                send_pair(16'd5, 16'd8);
                send_pair(16'd13, 16'd21);
                go_idle();
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(negedge clk);
                    if (out_valid && out_ready && out_idx == 16'd3) seen = 1'b1;
                end
                chk("bp_reach_idx3", 32'(seen), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(out_valid), 32'd1);
                    chk("bp_data", 32'(out_data), 32'd5);
                    chk("bp_idx", 32'(out_idx), 32'd4);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Overflow: 16-bit Fibonacci up to idx 25
        do_reset();
        fa = 16'd1;
        fb = 16'd1;
        for (int p = 0; p < 13; p++) begin
            send_pair(fa, fb);
            fa = fa + fb;
            fb = fa + fb;
        end
        go_idle();
        wait_drain();
        chk("ovf_wrap_sticky", 32'(wrap), 32'd1);
        chk("ovf_final_idx", 32'(out_idx), 32'd26);

        // Async reset while SECOND shows 3
        do_reset();
        send_pair(16'd2, 16'd3);
        go_idle();
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (out_valid && out_data == 16'd3) seen = 1'b1;
        end
        chk("ar_reach_3", 32'(seen), 32'd1);
        #1 rst = 1'b0;
        model_clear();
        #1;
        chk("ar_valid_drop", 32'(out_valid), 32'd0);
        chk("ar_idx_clear", 32'(out_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_pair(16'd1, 16'd1);
        go_idle();
        wait_drain();
        chk("ar_wrap", 32'(wrap), 32'd0);
        chk("ar_final_idx", 32'(out_idx), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
